// File: rtl/udc_pkg.sv
// Shared types and helpers for the bounded up/down counter.
// Holds the operation encoding, the per-edge priority decode and the
// wrap-mode constants used by the top level and the next-value calculator.
package udc_pkg;

    // Values for the WRAP parameter.
    localparam int WRAP_SAT  = 0;  // stop at the violated bound
    localparam int WRAP_ROLL = 1;  // continue from the opposite bound

    // Operation selected for the coming clock edge.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_DOWN = 2'd2,
        OP_UP   = 2'd3
    } op_e;

    // Priority decode: bad bounds > load > down > up > hold.
    // en qualifies the count requests only, never the load.
    function automatic op_e udc_decode(
        input logic load,
        input logic up,
        input logic down,
        input logic en,
        input logic cfg_err
    );
        op_e op;
        op = OP_HOLD;
        if (cfg_err) begin
            op = OP_HOLD;
        end else if (load) begin
            op = OP_LOAD;
        end else if (en && down) begin
            op = OP_DOWN;
        end else if (en && up) begin
            op = OP_UP;
        end
        return op;
    endfunction

endpackage

// File: rtl/udc_next_calc.sv
// Combinational next-count and overflow/underflow event calculation.
// All bound comparisons are made one bit wider than the count so that
// count+step and min_val+step never wrap before being compared.
// When the count has been left outside the bounds by a run-time bound
// change, a count request only pulls it back onto the violated bound on
// that edge; the step is not applied and no event is flagged.
module udc_next_calc
    import udc_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STEP_W = 3,
    parameter int WRAP   = WRAP_SAT
) (
    input  op_e               op,
    input  logic [WIDTH-1:0]  count,
    input  logic [WIDTH-1:0]  in_val,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    output logic [WIDTH-1:0]  count_nx,
    output logic              ovf_nx,
    output logic              udf_nx
);

    logic [WIDTH:0]   ext_count;
    logic [WIDTH:0]   ext_step;
    logic [WIDTH:0]   ext_min;
    logic [WIDTH:0]   ext_max;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_floor;
    logic [WIDTH-1:0] step_w;

    // Widened operands; step is zero-extended.
    always_comb begin
        ext_count = {1'b0, count};
        ext_step  = (WIDTH + 1)'(step);
        ext_min   = {1'b0, min_val};
        ext_max   = {1'b0, max_val};
        step_w    = WIDTH'(step);
        up_sum    = ext_count + ext_step;
        // count - step < min  <=>  count < min + step, with no borrow.
        dn_floor  = ext_min + ext_step;
    end

    // Select the next count and event flags for the decoded operation.
    always_comb begin
        count_nx = count;
        ovf_nx   = 1'b0;
        udf_nx   = 1'b0;
        unique case (op)
            OP_LOAD: begin
                if (in_val < min_val) begin
                    count_nx = min_val;
                end else if (in_val > max_val) begin
                    count_nx = max_val;
                end else begin
                    count_nx = in_val;
                end
            end
            OP_UP: begin
                if (count < min_val) begin
                    count_nx = min_val;
                end else if (count > max_val) begin
                    count_nx = max_val;
                end else if ((WRAP == WRAP_SAT) && (count == max_val)) begin
                    // Parked at the top: keep reporting the overflow.
                    count_nx = max_val;
                    ovf_nx   = 1'b1;
                end else if (up_sum > ext_max) begin
                    count_nx = (WRAP == WRAP_ROLL) ? min_val : max_val;
                    ovf_nx   = 1'b1;
                end else begin
                    count_nx = count + step_w;
                end
            end
            OP_DOWN: begin
                if (count < min_val) begin
                    count_nx = min_val;
                end else if (count > max_val) begin
                    count_nx = max_val;
                end else if ((WRAP == WRAP_SAT) && (count == min_val)) begin
                    // Parked at the bottom: keep reporting the underflow.
                    count_nx = min_val;
                    udf_nx   = 1'b1;
                end else if (ext_count < dn_floor) begin
                    count_nx = (WRAP == WRAP_ROLL) ? max_val : min_val;
                    udf_nx   = 1'b1;
                end else begin
                    count_nx = count - step_w;
                end
            end
            default: begin
                count_nx = count;
            end
        endcase
    end

endmodule

// File: rtl/bounded_up_dn_counter.sv
// Bounded up/down counter with run-time bounds, saturate or wrap mode,
// count enable and registered overflow/underflow pulses.
// Optional sticky status bits are built when UDC_STICKY_STATUS_EN is defined.
module bounded_up_dn_counter
    import udc_pkg::*;
#(
    parameter int          WIDTH     = 5,
    parameter int          STEP_W    = 3,
    parameter int unsigned RESET_VAL = 0,
    parameter int          WRAP      = WRAP_SAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  in,
    input  logic              up,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    output logic [WIDTH-1:0]  count,
    output logic              high,
    output logic              low,
    output logic              ovf,
    output logic              udf,
    output logic              cfg_err
`ifdef UDC_STICKY_STATUS_EN
    ,
    input  logic              sts_clr,
    output logic              sts_ovf,
    output logic              sts_udf
`endif
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             udf_q;
    logic             udf_d;
    op_e              op;

    // Bound compares and operation decode for this cycle.
    always_comb begin
        cfg_err = (min_val > max_val);
        high    = (count_q == max_val);
        low     = (count_q == min_val);
        op      = udc_decode(load, up, down, en, cfg_err);
    end

    udc_next_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W),
        .WRAP   (WRAP)
    ) u_next_calc (
        .op       (op),
        .count    (count_q),
        .in_val   (in),
        .step     (step),
        .min_val  (min_val),
        .max_val  (max_val),
        .count_nx (count_d),
        .ovf_nx   (ovf_d),
        .udf_nx   (udf_d)
    );

    // Count and event registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= WIDTH'(RESET_VAL);
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

`ifdef UDC_STICKY_STATUS_EN
    logic sts_ovf_q;
    logic sts_ovf_d;
    logic sts_udf_q;
    logic sts_udf_d;

    // Sticky bits rise with their event pulse; a new event beats a clear.
    always_comb begin
        sts_ovf_d = ovf_d | (sts_ovf_q & ~sts_clr);
        sts_udf_d = udf_d | (sts_udf_q & ~sts_clr);
    end

    // Sticky status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sts_ovf_q <= 1'b0;
            sts_udf_q <= 1'b0;
        end else begin
            sts_ovf_q <= sts_ovf_d;
            sts_udf_q <= sts_udf_d;
        end
    end

    assign sts_ovf = sts_ovf_q;
    assign sts_udf = sts_udf_q;
`endif

endmodule
